logit_pwl_pipe: RTL

- Pipelined piecewise-linear inverse sigmoid (logit), the reverse mapping of the team's sigmoid PWL unit.
- Input is a probability in Q8.8 (0x0000..0x0100 = 0.0..1.0); output is a signed Q8.8 logit, saturated to ±SAT_MAG.
- Sits in the activation/post-processing datapath behind a valid/ready stream; slopes use shift-add only, no multipliers.

---
 rtl/act_pkg.sv | 44 ++++
 rtl/logit_seg_lut.sv | 35 +++
 rtl/logit_pwl_pipe.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared activation-unit types and Q8.8 constants.
// Used by the logit PWL pipeline and its segment classifier.
package act_pkg;

  localparam logic [15:0] ONE_Q88     = 16'h0100;
  localparam logic [15:0] HALF_Q88    = 16'h0080;
  localparam logic [15:0] SAT_MAG_DEF = 16'h0800;

  localparam logic [7:0] ANC_A = 8'h80;
  localparam logic [7:0] ANC_B = 8'h60;
  localparam logic [7:0] ANC_C = 8'h30;
  localparam logic [7:0] ANC_D = 8'h10;

  localparam logic [11:0] BASE_A = 12'h000;
  localparam logic [11:0] BASE_B = 12'h080;
  localparam logic [11:0] BASE_C = 12'h170;
  localparam logic [11:0] BASE_D = 12'h2B0;

  typedef enum logic [1:0] {
    SEG_A,
    SEG_B,
    SEG_C,
    SEG_D
  } seg_e;

  typedef struct packed {
    logic       neg;
    logic       sat_n;
    logic       sat_p;
    logic       err;
    seg_e       seg;
    logic [7:0] d;
  } s1_t;

  typedef struct packed {
    logic        neg;
    logic        sat_n;
    logic        sat_p;
    logic        err;
    seg_e        seg;
    logic [11:0] m;
  } s2_t;

endpackage

// File: rtl/logit_seg_lut.sv
// Folded-probability classifier: q -> {segment, distance to anchor}.
// Each segment's lower bound is the next segment's anchor.
module logit_seg_lut
  import act_pkg::*;
(
  input  logic [7:0] i_q,
  output seg_e       o_seg,
  output logic [7:0] o_d
);

  // Pick the segment and measure how far q sits below its anchor
  always_comb begin
    o_seg = SEG_D;
    o_d   = ANC_D - i_q;
    unique case (1'b1)
      (i_q >= ANC_B): begin
        o_seg = SEG_A;
        o_d   = ANC_A - i_q;
      end
      (i_q >= ANC_C && i_q < ANC_B): begin
        o_seg = SEG_B;
        o_d   = ANC_B - i_q;
      end
      (i_q >= ANC_D && i_q < ANC_C): begin
        o_seg = SEG_C;
        o_d   = ANC_C - i_q;
      end
      (i_q < ANC_D): begin
        o_seg = SEG_D;
        o_d   = ANC_D - i_q;
      end
    endcase
  end

endmodule

// File: rtl/logit_pwl_pipe.sv
// Three-stage piecewise-linear logit (inverse sigmoid), Q8.8 in/out.
// Simple stall pipeline behind a valid/ready stream; shift-add slopes.
module logit_pwl_pipe
  import act_pkg::*;
#(
  parameter logic [15:0] SAT_MAG = SAT_MAG_DEF,
  parameter int          STAGES  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic        out_err
);

  logic [STAGES-1:0] r_vld;
  s1_t               r_s1;
  s2_t               r_s2;
  logic [15:0]       r_x;
  logic              r_err;

  logic        w_adv;
  logic        w_neg;
  logic        w_err;
  logic        w_satn;
  logic        w_satp;
  logic [7:0]  w_q;
  seg_e        w_seg;
  logic [7:0]  w_d;
  logic [11:0] w_d12;
  logic [11:0] w_m;
  logic [11:0] w_base;
  logic [11:0] w_mag;
  logic [15:0] w_x;

  assign w_adv     = !r_vld[STAGES-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign out_x     = r_x;
  assign out_err   = r_err;

  // Stage 1: fold around one half; 0x100 - p is just -p in 8 bits here
  assign w_err  = in_p[15] | (in_p > ONE_Q88);
  assign w_neg  = in_p < HALF_Q88;
  assign w_satn = in_p[15] | (in_p == 16'h0000);
  assign w_satp = !in_p[15] & (in_p >= ONE_Q88);
  assign w_q    = w_neg ? in_p[7:0] : (8'h00 - in_p[7:0]);

  logit_seg_lut u_lut (
    .i_q   (w_q),
    .o_seg (w_seg),
    .o_d   (w_d)
  );

  // Stage 2: slope times distance using shifts and adds only
  assign w_d12 = {4'b0000, r_s1.d};

  always_comb begin
    w_m = w_d12 << 2;
    unique case (r_s1.seg)
      SEG_A: w_m = w_d12 << 2;
      SEG_B: w_m = (w_d12 << 2) + w_d12;
      SEG_C: w_m = (w_d12 << 3) + (w_d12 << 1);
      SEG_D: w_m = (w_d12 << 5) + (w_d12 << 4);
    endcase
  end

  // Stage 3: add segment bias, apply sign, then saturation overrides
  always_comb begin
    w_base = BASE_A;
    unique case (r_s2.seg)
      SEG_A: w_base = BASE_A;
      SEG_B: w_base = BASE_B;
      SEG_C: w_base = BASE_C;
      SEG_D: w_base = BASE_D;
    endcase
  end

  assign w_mag = w_base + r_s2.m;

  always_comb begin
    w_x = {4'b0000, w_mag};
    unique case (1'b1)
      r_s2.sat_n:
        w_x = 16'h0000 - SAT_MAG;
      (!r_s2.sat_n && r_s2.sat_p):
        w_x = SAT_MAG;
      (!r_s2.sat_n && !r_s2.sat_p && r_s2.neg):
        w_x = 16'h0000 - {4'b0000, w_mag};
      (!r_s2.sat_n && !r_s2.sat_p && !r_s2.neg):
        w_x = {4'b0000, w_mag};
    endcase
  end

  // Valid bits march with the data; everything holds on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[STAGES-2:0], in_valid};
    end
  end

  // Stage 1 register: fold/classify result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
    end else if (w_adv) begin
      r_s1.neg   <= w_neg;
      r_s1.sat_n <= w_satn;
      r_s1.sat_p <= w_satp;
      r_s1.err   <= w_err;
      r_s1.seg   <= w_seg;
      r_s1.d     <= w_d;
    end
  end

  // Stage 2 register: slope product plus forwarded flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2 <= '0;
    end else if (w_adv) begin
      r_s2.neg   <= r_s1.neg;
      r_s2.sat_n <= r_s1.sat_n;
      r_s2.sat_p <= r_s1.sat_p;
      r_s2.err   <= r_s1.err;
      r_s2.seg   <= r_s1.seg;
      r_s2.m     <= w_m;
    end
  end

  // Stage 3 register: final logit and error sideband
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= 16'h0000;
      r_err <= 1'b0;
    end else if (w_adv) begin
      r_x   <= w_x;
      r_err <= r_s2.err;
    end
  end

endmodule
